// File: rtl/lsu_mem_port.sv
// Load/store unit memory port: one core request at a time, legality check,
// byte-lane steering for stores and lane extraction / extension for loads.
//
// state | meaning
// IDLE  | ready for a core request (t_req_ready=1)
// REQ   | memory request presented, waiting for i_mem_ready
// WAIT  | load issued, waiting for t_mem_valid
// RSP   | response presented, waiting for i_rsp_ready
module lsu_mem_port #(
  parameter int unsigned ADDR_W = 15
) (
  input  logic              clk,
  input  logic              rstf,
  input  logic              t_req_valid,
  output logic              t_req_ready,
  input  logic              t_req_we,
  input  logic [31:0]       t_req_addr,
  input  logic [2:0]        t_req_funct3,
  input  logic [31:0]       t_req_wdata,
  output logic              i_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [31:0]       i_rsp_data,
  output logic              i_rsp_err,
  output logic              i_mem_valid,
  input  logic              i_mem_ready,
  output logic              i_mem_we,
  output logic [ADDR_W-1:0] i_mem_addr,
  output logic [3:0][7:0]   i_mem_data,
  output logic [3:0]        i_mem_mask,
  input  logic              t_mem_valid,
  input  logic [3:0][7:0]   t_mem_data,
  output logic              t_mem_ready
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RSP  = 2'd3
  } state_t;

  state_t            state_q;
  logic              we_q;
  logic [1:0]        addr_lo_q;
  logic [2:0]        funct3_q;

  logic              rsp_valid_q;
  logic [31:0]       rsp_data_q;
  logic              rsp_err_q;
  logic              mem_valid_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [3:0][7:0]   mem_data_q;
  logic [3:0]        mem_mask_q;

  logic              req_err_d;
  logic [3:0][7:0]   mem_data_d;
  logic [3:0]        mem_mask_d;
  logic [31:0]       load_data_d;

  // Legality check and store lane steering, evaluated on the request inputs
  always_comb begin
    logic f3_ok;
    logic misalign;
    logic out_of_range;
    f3_ok        = 1'b0;
    misalign     = 1'b0;
    out_of_range = ((t_req_addr >> ADDR_W) != 32'd0);
    if (t_req_we) begin
      f3_ok = (t_req_funct3 == 3'b000) || (t_req_funct3 == 3'b001) ||
              (t_req_funct3 == 3'b010);
    end else begin
      f3_ok = (t_req_funct3 == 3'b000) || (t_req_funct3 == 3'b001) ||
              (t_req_funct3 == 3'b010) || (t_req_funct3 == 3'b100) ||
              (t_req_funct3 == 3'b101);
    end
    if (t_req_funct3[1:0] == 2'b01) begin
      misalign = t_req_addr[0];
    end else if (t_req_funct3[1:0] == 2'b10) begin
      misalign = (t_req_addr[1:0] != 2'b00);
    end
    req_err_d = !f3_ok || misalign || out_of_range;

    mem_data_d = '0;
    mem_mask_d = 4'b0000;
    if (t_req_we) begin
      case (t_req_funct3[1:0])
        2'b00: begin
          mem_data_d = {4{t_req_wdata[7:0]}};
          mem_mask_d = 4'b0001 << t_req_addr[1:0];
        end
        2'b01: begin
          mem_data_d = {2{t_req_wdata[15:0]}};
          mem_mask_d = t_req_addr[1] ? 4'b1100 : 4'b0011;
        end
        default: begin
          mem_data_d = t_req_wdata;
          mem_mask_d = 4'b1111;
        end
      endcase
    end
  end

  // Load lane extraction from the returned word
  always_comb begin
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    lane_b = t_mem_data[addr_lo_q];
    lane_h = addr_lo_q[1] ? {t_mem_data[3], t_mem_data[2]}
                          : {t_mem_data[1], t_mem_data[0]};
    case (funct3_q)
      3'b000:  load_data_d = {{24{lane_b[7]}}, lane_b};
      3'b001:  load_data_d = {{16{lane_h[15]}}, lane_h};
      3'b100:  load_data_d = {24'd0, lane_b};
      3'b101:  load_data_d = {16'd0, lane_h};
      default: load_data_d = t_mem_data;
    endcase
  end

  always_ff @(posedge clk or negedge rstf) begin
    if (!rstf) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      addr_lo_q   <= 2'b00;
      funct3_q    <= 3'b000;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 32'd0;
      rsp_err_q   <= 1'b0;
      mem_valid_q <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      mem_mask_q  <= 4'b0000;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (t_req_valid) begin
            we_q      <= t_req_we;
            addr_lo_q <= t_req_addr[1:0];
            funct3_q  <= t_req_funct3;
            if (req_err_d) begin
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_data_q  <= 32'd0;
              state_q     <= S_RSP;
            end else begin
              mem_valid_q <= 1'b1;
              mem_we_q    <= t_req_we;
              mem_addr_q  <= t_req_addr[ADDR_W-1:0];
              mem_data_q  <= mem_data_d;
              mem_mask_q  <= mem_mask_d;
              state_q     <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (i_mem_ready) begin
            mem_valid_q <= 1'b0;
            if (we_q) begin
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b0;
              rsp_data_q  <= 32'd0;
              state_q     <= S_RSP;
            end else begin
              state_q <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (t_mem_valid) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= load_data_d;
            state_q     <= S_RSP;
          end
        end
        S_RSP: begin
          if (i_rsp_ready) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= 32'd0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign t_req_ready = (state_q == S_IDLE);
  assign t_mem_ready = 1'b1;
  assign i_rsp_valid = rsp_valid_q;
  assign i_rsp_data  = rsp_data_q;
  assign i_rsp_err   = rsp_err_q;
  assign i_mem_valid = mem_valid_q;
  assign i_mem_we    = mem_we_q;
  assign i_mem_addr  = mem_addr_q;
  assign i_mem_data  = mem_data_q;
  assign i_mem_mask  = mem_mask_q;

endmodule

// File: doc/lsu_mem_port.md
LSU_MEM_PORT -- requirements
Module: lsu_mem_port

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 15, giving the memory byte-address width (8192 words x 4 bytes).
REQ-002 The port list SHALL be clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The port list SHALL be rstf, input, 1; reset is asynchronous and active-low.
REQ-004 The port list SHALL be t_req_valid/t_req_ready, input/output, 1/1, the core request handshake.
REQ-005 The port list SHALL be t_req_we, input, 1: 1=store, 0=load.
REQ-006 The port list SHALL be t_req_addr, input, 32, the byte address.
REQ-007 The port list SHALL be t_req_funct3, input, 3, the RISC-V width code (LB/LH/LW/LBU/LHU, SB/SH/SW).
REQ-008 The port list SHALL be t_req_wdata, input, 32, store data right-aligned.
REQ-009 The port list SHALL be i_rsp_valid/i_rsp_ready, output/input, 1/1, the core response handshake.
REQ-010 The port list SHALL be i_rsp_data, output, 32: load result extended to 32 bits; 0 for stores and errors.
REQ-011 The port list SHALL be i_rsp_err, output, 1: misaligned, illegal funct3 or out-of-range address.
REQ-012 The port list SHALL be i_mem_valid/i_mem_ready, output/input, 1/1, the memory request handshake.
REQ-013 The port list SHALL be i_mem_we, output, 1; i_mem_addr, output, ADDR_W; i_mem_data, output, 4x8 packed; i_mem_mask, output, 4.
REQ-014 The port list SHALL be t_mem_valid, input, 1, and t_mem_data, input, 4x8, the memory read return.
REQ-015 The port list SHALL be t_mem_ready, output, 1, tied to 1.

Function
REQ-016 The FSM SHALL have states IDLE, REQ, WAIT, RSP; t_req_ready=1 only in IDLE.
REQ-017 On request acceptance, the block SHALL register we, addr, funct3 and wdata, then check legality.
REQ-018 An access SHALL be an error if halfword addr[0]!=0, word addr[1:0]!=0, funct3 is illegal (loads 011/110/111; stores >=011), or addr[31:ADDR_W]!=0.
REQ-019 On error, the FSM SHALL go IDLE->RSP with i_rsp_err=1 and data 0; no memory request SHALL be issued.
REQ-020 For a legal access, IDLE->REQ: i_mem_valid=1 from the cycle after acceptance, held with stable payload until i_mem_ready.
REQ-021 Memory outputs SHALL be: i_mem_addr = addr[ADDR_W-1:0]; i_mem_we = stored we.
REQ-022 Store lanes: SB data={4{b}}, mask=1<<addr[1:0]; SH data={2{h}}, mask 0011/1100 by addr[1]; SW data=wdata, mask 1111.
REQ-023 Loads SHALL drive mask 0000 and data 0.
REQ-024 Store accepted by memory (REQ with i_mem_ready) SHALL go REQ->RSP, data 0, err 0.
REQ-025 Load accepted by memory SHALL go REQ->WAIT; t_mem_data with t_mem_valid (one cycle later) SHALL be captured, then WAIT->RSP.
REQ-026 Load extraction: byte lane addr[1:0] or halfword lane addr[1]; LB/LH sign-extend, LBU/LHU zero-extend, LW unchanged.
REQ-027 In RSP, i_rsp_valid=1 with data/err stable until i_rsp_ready, then ->IDLE; no back-to-back: minimum 1 idle cycle between responses and next accept.
REQ-028 t_mem_valid outside WAIT SHALL be ignored; WAIT SHALL persist with no timeout until t_mem_valid.
REQ-029 Only one transaction SHALL be outstanding at any time.

Reset
REQ-030 rstf low SHALL asynchronously force IDLE, i_mem_valid=0, i_rsp_valid=0, i_rsp_err=0, i_rsp_data=0, i_mem_we=0, i_mem_mask=0, i_mem_addr=0, i_mem_data=0.
REQ-031 Reset mid-transaction SHALL abandon it silently; a late t_mem_valid after release SHALL be ignored.

Verification
REQ-032 SW addr 0x10 data 0xDEADBEEF, i_mem_ready=1 -> i_mem mask 1111, addr 0x10; response data 0, err 0.
REQ-033 SB addr 0x13 data 0x000000A5 -> data 0xA5A5A5A5, mask 1000; then LB addr 0x13 with return 0xA5xxxxxx -> rsp 0xFFFFFFA5; LBU -> 0x000000A5.
REQ-034 LH addr 0x22 with return 0x8001_xxxx -> rsp 0xFFFF8001; LHU -> 0x00008001.
REQ-035 LW addr 0x6, SH addr 0x1, funct3 011 load, or addr 0x00010000 -> err=1, data 0, i_mem_valid never asserted.
REQ-036 Backpressure: i_mem_ready low 3 cycles then i_rsp_ready low 2 cycles -> payloads stable throughout, exactly one memory transaction and one response.
REQ-037 rstf pulsed low while in WAIT -> outputs zero immediately; a stray t_mem_valid next cycle produces no response.
